// File: rtl/glyph_line_sched.sv
// glyph_line_sched: walks one text line, turns each character code into a glyph
// via the column ROM and streams the selected glyph row out as serial pixels.
module glyph_line_sched #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] char_cnt,
    input  logic [2:0]        glyph_row,
    output logic              busy,
    output logic              done,
    output logic              text_rd,
    output logic [ADDR_W-1:0] text_addr,
    input  logic [5:0]        text_data,
    output logic [5:0]        glyph_code,
    input  logic [7:0]        glyph_col0,
    input  logic [7:0]        glyph_col1,
    input  logic [7:0]        glyph_col2,
    input  logic [7:0]        glyph_col3,
    input  logic [7:0]        glyph_col4,
    input  logic [7:0]        glyph_col5,
    input  logic [7:0]        glyph_col6,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_data,
    output logic              pix_last
);

    localparam int unsigned CODE_W = 6;
    localparam int unsigned NCOLS  = 7;
    localparam int unsigned PCNT_W = 3;
    localparam int unsigned ROW_W  = 3;

    localparam logic [CODE_W-1:0] CODE_SPACE = CODE_W'(8'h3E);
    localparam logic [PCNT_W-1:0] LAST_COL   = PCNT_W'(NCOLS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TXT   = 3'd1,
        CODE  = 3'd2,
        ROM   = 3'd3,
        LOAD  = 3'd4,
        SHIFT = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t state;
    state_t state_nxt;

    // Line context captured at start
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic [ROW_W-1:0]  row_q;
    logic [ROW_W-1:0]  row_d;

    // Per-character progress
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_d;
    logic [PCNT_W-1:0] pcnt_q;
    logic [PCNT_W-1:0] pcnt_d;
    logic [NCOLS-1:0]  shift_q;
    logic [NCOLS-1:0]  shift_d;

    // Next values of the registered outputs
    logic              busy_d;
    logic              done_d;
    logic              text_rd_d;
    logic [ADDR_W-1:0] text_addr_d;
    logic [CODE_W-1:0] glyph_code_d;
    logic              pix_valid_d;
    logic              pix_data_d;
    logic              pix_last_d;

    logic              pix_fire;
    logic              last_pix;
    logic              last_char;
    logic [NCOLS-1:0]  load_bits;

    assign pix_fire  = pix_valid && pix_ready;
    assign last_pix  = (pcnt_q == LAST_COL);
    assign last_char = (ADDR_W'(idx_q + 1'b1) == cnt_q);

    // Row slice of the current glyph; column 0 lands in bit 0 so it shifts out first
    assign load_bits = {glyph_col6[row_q], glyph_col5[row_q], glyph_col4[row_q],
                        glyph_col3[row_q], glyph_col2[row_q], glyph_col1[row_q],
                        glyph_col0[row_q]};

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: fetch chain, then pixel drain, then next char or end of line
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (char_cnt != '0) ? TXT : DONE;
                end
            end
            TXT:   state_nxt = CODE;
            CODE:  state_nxt = ROM;
            ROM:   state_nxt = LOAD;
            LOAD:  state_nxt = SHIFT;
            SHIFT: begin
                if (pix_fire && last_pix) begin
                    state_nxt = last_char ? DONE : TXT;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output and datapath next values; every output is a function of the next state
    always_comb begin
        cnt_d        = cnt_q;
        row_d        = row_q;
        idx_d        = idx_q;
        pcnt_d       = pcnt_q;
        shift_d      = shift_q;
        text_addr_d  = text_addr;
        glyph_code_d = glyph_code;

        case (state)
            IDLE: begin
                if (start) begin
                    cnt_d       = char_cnt;
                    row_d       = glyph_row;
                    idx_d       = '0;
                    text_addr_d = base_addr;
                end
            end
            CODE: begin
                glyph_code_d = text_data;
            end
            LOAD: begin
                shift_d = load_bits;
                pcnt_d  = '0;
            end
            SHIFT: begin
                if (pix_fire) begin
                    shift_d = shift_q >> 1;
                    pcnt_d  = PCNT_W'(pcnt_q + 1'b1);
                    if (last_pix && !last_char) begin
                        idx_d       = ADDR_W'(idx_q + 1'b1);
                        // address wraps modulo the buffer size
                        text_addr_d = ADDR_W'(text_addr + 1'b1);
                    end
                end
            end
            default: ;
        endcase

        busy_d      = (state_nxt != IDLE);
        done_d      = (state_nxt == DONE);
        text_rd_d   = (state_nxt == TXT);
        pix_valid_d = (state_nxt == SHIFT);
        pix_data_d  = (state_nxt == SHIFT) && shift_d[0];
        pix_last_d  = (state_nxt == SHIFT) && (pcnt_d == LAST_COL) && last_char;
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q      <= '0;
            row_q      <= '0;
            idx_q      <= '0;
            pcnt_q     <= '0;
            shift_q    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            text_rd    <= 1'b0;
            text_addr  <= '0;
            glyph_code <= CODE_SPACE;
            pix_valid  <= 1'b0;
            pix_data   <= 1'b0;
            pix_last   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            idx_q      <= idx_d;
            pcnt_q     <= pcnt_d;
            shift_q    <= shift_d;
            busy       <= busy_d;
            done       <= done_d;
            text_rd    <= text_rd_d;
            text_addr  <= text_addr_d;
            glyph_code <= glyph_code_d;
            pix_valid  <= pix_valid_d;
            pix_data   <= pix_data_d;
            pix_last   <= pix_last_d;
        end
    end

endmodule

// File: tb/tb_glyph_line_sched.sv
// Bench for glyph_line_sched: text buffer and glyph ROM models, a line-level
// pixel/address model, a per-cycle compare process and directed line tests.
module tb_glyph_line_sched;

    localparam int unsigned ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] char_cnt;
    logic [2:0]        glyph_row;
    logic              busy;
    logic              done;
    logic              text_rd;
    logic [ADDR_W-1:0] text_addr;
    logic [5:0]        text_data;
    logic [5:0]        glyph_code;
    logic [7:0]        rom_col [7];
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_data;
    logic              pix_last;

    glyph_line_sched #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .char_cnt   (char_cnt),
        .glyph_row  (glyph_row),
        .busy       (busy),
        .done       (done),
        .text_rd    (text_rd),
        .text_addr  (text_addr),
        .text_data  (text_data),
        .glyph_code (glyph_code),
        .glyph_col0 (rom_col[0]),
        .glyph_col1 (rom_col[1]),
        .glyph_col2 (rom_col[2]),
        .glyph_col3 (rom_col[3]),
        .glyph_col4 (rom_col[4]),
        .glyph_col5 (rom_col[5]),
        .glyph_col6 (rom_col[6]),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_last   (pix_last)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int t0     = 0;
    bit chk_on = 1'b0;

    logic [5:0] tmem [64];

    // Expected streams: {last, pixel} per pixel and read addresses per character
    logic [1:0]        exp_pix  [$];
    logic [ADDR_W-1:0] exp_addr [$];

    // Per-line observations, relative to the start cycle
    int                first_rd, first_valid, last_rel, done_rel;
    int                npix, nlast, ndone, nrd, nstall_hi;
    logic [5:0]        gc3;
    logic [31:0]       word;
    logic              busy_log [64];
    logic [ADDR_W-1:0] addr_log [$];

    // Font: column bytes, bit r = glyph row r
    function automatic logic [7:0] font(input logic [5:0] code, input int col);
        logic [7:0] g [7];
        case (code)
            6'h00:   g = '{8'h00, 8'h3E, 8'h41, 8'h41, 8'h41, 8'h3E, 8'h00};
            6'h01:   g = '{8'h00, 8'h00, 8'h42, 8'h7F, 8'h40, 8'h00, 8'h00};
            6'h3E:   g = '{default: 8'h00};
            default: g = '{8'h00, 8'h22, 8'h14, 8'h08, 8'h14, 8'h22, 8'h00};
        endcase
        return g[col];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Text buffer: one-cycle read latency
    always @(posedge clk) if (text_rd) text_data <= tmem[text_addr];

    // Glyph ROM: samples the code every edge
    always @(posedge clk) for (int k = 0; k < 7; k++) rom_col[k] <= font(glyph_code, k);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: unexpected event (t=%0t)", name, $time);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"},       busy,       0);
        check({tag, "_done"},       done,       0);
        check({tag, "_text_rd"},    text_rd,    0);
        check({tag, "_text_addr"},  text_addr,  0);
        check({tag, "_glyph_code"}, glyph_code, 32'h3E);
        check({tag, "_pix_valid"},  pix_valid,  0);
        check({tag, "_pix_data"},   pix_data,   0);
        check({tag, "_pix_last"},   pix_last,   0);
    endtask

    // Line model: read address and every pixel of every character
    task automatic model_line(input logic [5:0] b, input logic [5:0] n, input logic [2:0] r);
        for (int i = 0; i < int'(n); i++) begin
            logic [ADDR_W-1:0] a;
            a = ADDR_W'(b + i);
            exp_addr.push_back(a);
            for (int k = 0; k < 7; k++) begin
                logic [7:0] fb;
                fb = font(tmem[a], k);
                exp_pix.push_back({(i == int'(n) - 1) && (k == 6), fb[r]});
            end
        end
    endtask

    // Compare process
    always @(negedge clk) begin
        int rel;
        logic [1:0] e;
        if (rst && chk_on) begin
            rel = cyc - t0;
            if (rel >= 0 && rel < 64) busy_log[rel] = busy;
            if (rel == 3) gc3 = glyph_code;
            if (text_rd) begin
                nrd++;
                if (first_rd < 0) first_rd = rel;
                addr_log.push_back(text_addr);
                if (exp_addr.size() == 0) fail("extra_read");
                else check("text_addr", text_addr, exp_addr.pop_front());
            end
            if (pix_valid) begin
                if (first_valid < 0) first_valid = rel;
                if (exp_pix.size() == 0) begin
                    fail("extra_pixel");
                end else begin
                    e = exp_pix[0];
                    check("pix_data", pix_data, e[0]);
                    check("pix_last", pix_last, e[1]);
                    if (pix_ready) begin
                        void'(exp_pix.pop_front());
                        if (npix < 32) word[npix] = pix_data;
                        npix++;
                        if (pix_last) begin
                            nlast++;
                            last_rel = rel;
                        end
                    end else if (pix_data) begin
                        nstall_hi++;
                    end
                end
            end else begin
                check("pix_last_idle", pix_last, 0);
            end
            if (done) begin
                ndone++;
                done_rel = rel;
                check("done_drained", exp_pix.size() + exp_addr.size(), 0);
            end
        end
    end

    // Run one line starting in the current cycle (called just after a rising edge)
    task automatic run_line(input logic [5:0] b, input logic [5:0] n, input logic [2:0] r,
                            input int stall_at, input int stall_len,
                            input int xs1, input int xs2, input bit start_in_done,
                            input int rst_at, input int max_cyc);
        int post;
        int rel;
        first_rd = -1; first_valid = -1; last_rel = -1; done_rel = -1;
        npix = 0; nlast = 0; ndone = 0; nrd = 0; nstall_hi = 0;
        word = '0; gc3 = 'x;
        addr_log.delete();
        for (int i = 0; i < 64; i++) busy_log[i] = 1'bx;
        model_line(b, n, r);
        t0        = cyc;
        base_addr = b;
        char_cnt  = n;
        glyph_row = r;
        start     = 1'b1;
        pix_ready = 1'b1;
        post      = -1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(posedge clk);
            #1;
            rel       = cyc - t0;
            start     = 1'b0;
            base_addr = ~b;
            char_cnt  = ~n;
            glyph_row = ~r;
            pix_ready = !(rel >= stall_at && rel < stall_at + stall_len);
            if (rel == xs1 || rel == xs2) start = 1'b1;
            if (start_in_done && done) start = 1'b1;
            if (rel == rst_at) begin
                rst = 1'b0;
                exp_pix.delete();
                exp_addr.delete();
            end else begin
                rst = 1'b1;
            end
            if (rel == rst_at + 1) check_reset("abort");
            if (post < 0 && ndone > 0) post = rel + 12;
            if (post >= 0 && rel >= post) break;
        end
        start = 1'b0;
        pix_ready = 1'b1;
        if (rst_at < 0 && ndone == 0) fail("line_timeout");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; start = 1'b0; base_addr = '0; char_cnt = '0; glyph_row = '0;
        pix_ready = 1'b1;
        for (int i = 0; i < 64; i++) tmem[i] = 6'h3E;
        tmem[5]  = 6'h01;
        tmem[0]  = 6'h00;
        tmem[1]  = 6'h01;
        tmem[63] = 6'h24;
        tmem[20] = 6'h01;
        tmem[21] = 6'h00;
        tmem[22] = 6'h01;

        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b1;
        chk_on = 1'b1;
        @(posedge clk); #1;

        // single "1", row 1
        run_line(6'd5, 6'd1, 3'd1, -100, 0, -1, -1, 1'b0, -1, 60);
        check("A_first_rd",    first_rd, 1);
        check("A_glyph_code3", gc3, 1);
        check("A_first_valid", first_valid, 5);
        check("A_pixels",      word, 32'h0C);
        check("A_last_cycle",  last_rel, 11);
        check("A_done_cycle",  done_rel, 12);
        check("A_ndone",       ndone, 1);
        check("A_busy0",       busy_log[0], 0);
        check("A_busy1",       busy_log[1], 1);
        check("A_busy12",      busy_log[12], 1);
        check("A_busy13",      busy_log[13], 0);

        // "0","1" at row 6
        run_line(6'd0, 6'd2, 3'd6, -100, 0, -1, -1, 1'b0, -1, 80);
        check("B_pixels",     word, 32'hE1C);
        check("B_npix",       npix, 14);
        check("B_nlast",      nlast, 1);
        check("B_last_cycle", last_rel, 22);
        check("B_done_cycle", done_rel, 23);

        // backpressure: ready low for 3 cycles at pixel 2
        run_line(6'd5, 6'd1, 3'd1, 7, 3, -1, -1, 1'b0, -1, 60);
        check("C_stall_hold", nstall_hi, 3);
        check("C_pixels",     word, 32'h0C);
        check("C_last_cycle", last_rel, 14);
        check("C_done_cycle", done_rel, 15);

        // empty line, with a start in the DONE cycle
        run_line(6'd9, 6'd0, 3'd0, -100, 0, -1, -1, 1'b1, -1, 30);
        check("D_done_cycle", done_rel, 1);
        check("D_nrd",        nrd, 0);
        check("D_npix",       npix, 0);
        check("D_busy0",      busy_log[0], 0);
        check("D_busy1",      busy_log[1], 1);
        check("D_busy2",      busy_log[2], 0);

        // address wrap 63 -> 0, undefined code 0x24 first
        run_line(6'd63, 6'd2, 3'd1, -100, 0, -1, -1, 1'b0, -1, 80);
        check("E_addr0",      addr_log.size() > 0 ? addr_log[0] : 6'h2A, 63);
        check("E_addr1",      addr_log.size() > 1 ? addr_log[1] : 6'h2A, 0);
        check("E_star_row1",  word[6:0], 7'h22);
        check("E_pixels",     word, 32'h1122);
        check("E_done_cycle", done_rel, 23);

        // start pulses while busy and in DONE are ignored
        run_line(6'd20, 6'd2, 3'd0, -100, 0, 3, 8, 1'b1, -1, 80);
        check("F_pixels",     word, 32'hE08);
        check("F_nrd",        nrd, 2);
        check("F_done_cycle", done_rel, 23);
        check("F_ndone",      ndone, 1);

        // reset during SHIFT of char 0 in a 3-char line
        run_line(6'd20, 6'd3, 3'd1, -100, 0, -1, -1, 1'b0, 7, 40);
        check("G_ndone", ndone, 0);
        check("G_nrd",   nrd, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
